// File: rtl/systolic_ws_stream_ctrl.sv
// systolic_ws_stream_ctrl
//   Streaming front/back end for a weight-stationary ROW_NUM x COL_NUM PE array.
//   - Input side: accepts one activation vector per in_valid/in_ready handshake
//     and drives it onto the array's west inputs skewed by row (row i delayed i
//     cycles after the capture register). North inputs are tied to zero.
//   - Output side: de-skews the array's south outputs (column j delayed
//     COL_NUM-1-j cycles), buffers completed result vectors in a FIFO, and
//     presents them on out_valid/out_ready.
//   - The array cannot stall, so admission is credit based: a vector is only
//     accepted if a FIFO slot is guaranteed for its result.
// Ports:
//   clk        clock, all state on posedge
//   reset      asynchronous active-low reset
//   in_valid   activation vector offered
//   in_ready   vector accepted when in_valid && in_ready at posedge
//   in_data    activation vector, element i goes to row i
//   wests      skewed activations to the array west inputs
//   norths     array north inputs, constant zero
//   souths     array south outputs (partial-sum results)
//   out_valid  result vector available at FIFO head
//   out_ready  pop when out_valid && out_ready at posedge
//   out_data   result vector at FIFO head (zero when out_valid is low)
//   busy       a vector is in flight or the FIFO is non-empty
module systolic_ws_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [0:ROW_NUM-1][DATA_WIDTH-1:0]   in_data,
  output logic [0:ROW_NUM-1][DATA_WIDTH-1:0]   wests,
  output logic [0:COL_NUM-1][DATA_WIDTH-1:0]   norths,
  input  logic [0:COL_NUM-1][DATA_WIDTH-1:0]   souths,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [0:COL_NUM-1][DATA_WIDTH-1:0]   out_data,
  output logic                                 busy
);

  localparam int TRK_LEN = ROW_NUM + COL_NUM;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);

  logic                                 credit_ok;
  logic                                 accept;
  logic                                 fifo_wr;
  logic                                 fifo_nonempty;
  logic                                 pop;
  logic [CNT_W:0]                       credits_used;
  logic [CNT_W-1:0]                     inflight_q, inflight_d;
  logic [CNT_W-1:0]                     fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]                     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                     rd_ptr_q, rd_ptr_d;
  logic [TRK_LEN-1:0]                   trk_q;
  logic [0:COL_NUM-1][DATA_WIDTH-1:0]   aligned;
  logic [0:COL_NUM-1][DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  // Every accepted vector reserves a FIFO slot until it is popped, so the
  // array can never produce a result with nowhere to go.
  assign credits_used  = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign credit_ok     = credits_used < DEPTH_SUM;
  assign accept        = in_valid && credit_ok;
  assign fifo_nonempty = (fifo_count_q != '0);
  assign pop           = fifo_nonempty && out_ready;
  assign fifo_wr       = trk_q[TRK_LEN-1];

  // reset only gates the outputs; the flops are held clear by the async reset.
  assign in_ready  = reset && credit_ok;
  assign out_valid = reset && fifo_nonempty;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy      = (inflight_q != '0) || fifo_nonempty;
  assign norths    = '0;

  // Input skew: row gi holds gi+1 stages; bubbles shift in zeros.
  for (genvar gi = 0; gi < ROW_NUM; gi++) begin : g_row
    logic [DATA_WIDTH-1:0] skew_q [gi+1];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= gi; k++) skew_q[k] <= '0;
      end else begin
        skew_q[0] <= accept ? in_data[gi] : '0;
        for (int k = 1; k <= gi; k++) skew_q[k] <= skew_q[k-1];
      end
    end
    assign wests[gi] = skew_q[gi];
  end

  // De-skew: column gi waits COL_NUM-1-gi cycles so all columns line up with
  // the last one, which passes straight through.
  for (genvar gi = 0; gi < COL_NUM; gi++) begin : g_col
    localparam int DLY = COL_NUM - 1 - gi;
    if (DLY == 0) begin : g_pass
      assign aligned[gi] = souths[gi];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dsk_q [DLY];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < DLY; k++) dsk_q[k] <= '0;
        end else begin
          dsk_q[0] <= souths[gi];
          for (int k = 1; k < DLY; k++) dsk_q[k] <= dsk_q[k-1];
        end
      end
      assign aligned[gi] = dsk_q[DLY-1];
    end
  end

  // Valid tracker: the bit leaving the end marks the cycle in which the
  // aligned vector belongs to an accepted input rather than array garbage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trk_q <= '0;
    else        trk_q <= {trk_q[TRK_LEN-2:0], accept};
  end

  always_comb begin
    inflight_d   = inflight_q;
    fifo_count_d = fifo_count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    // Accept and write on the same edge cancel out.
    if (accept && !fifo_wr)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && fifo_wr) inflight_d = inflight_q - CNT_W'(1);
    if (fifo_wr && !pop)         fifo_count_d = fifo_count_q + CNT_W'(1);
    else if (!fifo_wr && pop)    fifo_count_d = fifo_count_q - CNT_W'(1);
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      assert (fifo_count_q != DEPTH_CNT);
      fifo_mem[wr_ptr_q] <= aligned;
    end
  end

endmodule

// File: tb/tb_systolic_ws_stream_ctrl.sv
// Testbench for systolic_ws_stream_ctrl. Includes a behavioural model of the
// weight-stationary array (driven from the DUT's wests) and a result
// scoreboard computed as plain dot products at accept time.
module tb_systolic_ws_stream_ctrl;
  localparam int DW  = 8;
  localparam int R   = 4;
  localparam int C   = 3;
  localparam int D   = 9;
  localparam int LAT = R + C + 1;
  localparam int HN  = 64;

  typedef logic [0:R-1][DW-1:0] ivec_t;
  typedef logic [0:C-1][DW-1:0] ovec_t;

  logic  clk       = 1'b0;
  logic  reset     = 1'b1;
  logic  in_valid  = 1'b0;
  logic  in_ready;
  ivec_t in_data   = '0;
  ivec_t wests;
  ovec_t norths;
  ovec_t souths    = '0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  ovec_t out_data;
  logic  busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] w [R][C];
  logic [DW-1:0] hist [HN][R];
  int            cyc = 0;
  ovec_t         exp_q[$];
  ovec_t         exp_v;

  logic  s_in_ready, s_out_valid, s_busy, fire_in, fire_out;
  ivec_t s_wests;
  ovec_t s_out;

  systolic_ws_stream_ctrl #(
    .DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wests(wests), .norths(norths), .souths(souths),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Array model: element i seen on wests at cycle t reaches column j's south
  // output ROW_NUM+j-i cycles later; PE state is never cleared, so stale
  // activations from before a reset still produce garbage on souths.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int i = 0; i < R; i++) hist[cyc % HN][i] = wests[i];
    for (int j = 0; j < C; j++) begin
      souths[j] = '0;
      for (int i = 0; i < R; i++)
        if (cyc - R - j + i >= 1)
          souths[j] = souths[j] + w[i][j] * hist[(cyc - R - j + i) % HN][i];
    end
  end

  function automatic ovec_t model(input ivec_t a);
    ovec_t r;
    for (int j = 0; j < C; j++) begin
      r[j] = '0;
      for (int i = 0; i < R; i++) r[j] = r[j] + a[i] * w[i][j];
    end
    return r;
  endfunction

  task automatic rand_weights();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) w[i][j] = DW'($urandom);
  endtask

  task automatic rand_input();
    for (int i = 0; i < R; i++) in_data[i] = DW'($urandom);
  endtask

  // One clock cycle: snapshot outputs at the negedge, log handshakes, then
  // return 2 time units after the next posedge so new inputs can be driven.
  task automatic step();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_busy      = busy;
    s_wests     = wests;
    s_out       = out_data;
    fire_in     = in_valid && in_ready;
    fire_out    = out_valid && out_ready;
    if (fire_in) exp_q.push_back(model(in_data));
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    checks++; if (wests !== '0) begin errors++; $display("FAIL rst_wests got=%h exp=0", wests); end
    in_valid = 1'b0;
    @(posedge clk); #2; reset = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    checks++; if (norths !== '0) begin errors++; $display("FAIL norths got=%h exp=0", norths); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    @(posedge clk); #2;
  endtask

  task automatic test_single();
    ivec_t a; ovec_t e; logic [DW-1:0] ew;
    rand_weights();
    rand_input(); a = in_data; e = model(a);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (fire_in !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", fire_in); end
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      for (int i = 0; i < R; i++) begin
        ew = (k == i + 1) ? a[i] : '0;
        checks++;
        if (s_wests[i] !== ew) begin errors++; $display("FAIL single_west row=%0d cyc=%0d got=%h exp=%h", i, k, s_wests[i], ew); end
      end
      checks++;
      if (s_out_valid !== (k == LAT)) begin errors++; $display("FAIL single_out_valid cyc=%0d got=%b exp=%b", k, s_out_valid, (k == LAT)); end
    end
    checks++; if (s_out !== e) begin errors++; $display("FAIL single_data got=%h exp=%h", s_out, e); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", s_busy); end
    step();
    checks++; if (s_busy !== 1'b0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b ov=%b exp 0 0", s_busy, s_out_valid); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) w[i][j] = (i == j) ? 8'd1 : 8'd0;
    out_ready = 1'b1;
    for (int s = 1; s <= 20 + LAT + 4; s++) begin
      in_valid = (s <= 20);
      rand_input();
      step();
      if (s <= 20) begin
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready step=%0d got=%b exp=1", s, s_in_ready); end
      end
      if (fire_out) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra got=%h exp=none", s_out); end
        else begin
          exp_v = exp_q.pop_front();
          if (s_out !== exp_v || s != LAT + 1 + pops) begin
            errors++; $display("FAIL b2b_out step=%0d got=%h exp=%h at step %0d", s, s_out, exp_v, LAT + 1 + pops);
          end
        end
        pops++;
      end
    end
    checks++; if (pops != 20) begin errors++; $display("FAIL b2b_count got=%0d exp=20", pops); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    rand_weights();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < D + LAT + 4; s++) begin rand_input(); step(); if (fire_in) acc++; end
    checks++; if (acc != D) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", acc, D); end
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", s_in_ready); end
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid got=%b exp=1", s_out_valid); end
    out_ready = 1'b1; step();
    checks++; if (fire_out !== 1'b1 || fire_in !== 1'b0) begin errors++; $display("FAIL bp_pop got pop=%b acc=%b exp 1 0", fire_out, fire_in); end
    if (fire_out && exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      checks++; if (s_out !== exp_v) begin errors++; $display("FAIL bp_pop_data got=%h exp=%h", s_out, exp_v); end
    end
    out_ready = 1'b0; rand_input(); step();
    checks++; if (fire_in !== 1'b1) begin errors++; $display("FAIL bp_new_accept got=%b exp=1", fire_in); end
    step();
    checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_refull got=%b exp=0", s_in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int s = 0; s < 2 * D + LAT && exp_q.size() > 0; s++) begin
      step();
      if (fire_out) begin
        exp_v = exp_q.pop_front();
        checks++; if (s_out !== exp_v) begin errors++; $display("FAIL bp_drain got=%h exp=%h", s_out, exp_v); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] ovf;
    int got = 0;
    ovf = DW'((R * 255 * 255) % 256);
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) w[i][j] = 8'hFF;
    out_ready = 1'b1; in_valid = 1'b1; in_data = '1;
    repeat (3) step();
    in_valid = 1'b0;
    for (int s = 0; s < 3 * LAT && got < 3; s++) begin
      step();
      if (fire_out) begin
        got++;
        void'(exp_q.pop_front());
        for (int j = 0; j < C; j++) begin
          checks++; if (s_out[j] !== ovf) begin errors++; $display("FAIL ovf_col%0d got=%h exp=%h", j, s_out[j], ovf); end
        end
      end
    end
    checks++; if (got != 3) begin errors++; $display("FAIL ovf_count got=%0d exp=3", got); end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int found = 0;
    rand_weights();
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin rand_input(); step(); end
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got=%b exp=1", s_out_valid); end
    in_valid = 1'b1;
    repeat (3) begin rand_input(); step(); end
    in_valid = 1'b0;
    reset = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got=%b exp=0", in_ready); end
    exp_q.delete();
    @(posedge clk); @(posedge clk); #2; reset = 1'b1;
    out_ready = 1'b1;
    for (int s = 1; s <= LAT + 4; s++) begin
      step();
      checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale step=%0d got=%h exp=no output", s, s_out); end
    end
    rand_input(); in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int k = 1; k <= 2 * LAT && found == 0; k++) begin
      step();
      if (s_out_valid) begin
        found = 1;
        checks++; if (k != LAT) begin errors++; $display("FAIL mid_latency got=%0d exp=%0d", k, LAT); end
        exp_v = exp_q.pop_front();
        checks++; if (s_out !== exp_v) begin errors++; $display("FAIL mid_data got=%h exp=%h", s_out, exp_v); end
      end
    end
    checks++; if (found == 0) begin errors++; $display("FAIL mid_timeout got=none exp=result"); end
  endtask

  task automatic test_random();
    int sent = 0, pops = 0;
    logic stalled = 1'b0;
    ovec_t prev_out = '0;
    rand_weights();
    for (int s = 0; s < 3000 && (sent < 100 || exp_q.size() > 0); s++) begin
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      rand_input();
      step();
      if (fire_in) sent++;
      if (stalled) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out !== prev_out) begin errors++; $display("FAIL rnd_stable got=%b/%h exp=1/%h", s_out_valid, s_out, prev_out); end
      end
      stalled  = s_out_valid && !out_ready;
      prev_out = s_out;
      if (fire_out) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra got=%h exp=none", s_out); end
        else begin
          exp_v = exp_q.pop_front();
          if (s_out !== exp_v) begin errors++; $display("FAIL rnd_data idx=%0d got=%h exp=%h", pops, s_out, exp_v); end
        end
        pops++;
      end
    end
    in_valid = 1'b0;
    checks++; if (pops != 100) begin errors++; $display("FAIL rnd_count got=%0d exp=100", pops); end
    step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rnd_final_busy got=%b exp=0", s_busy); end
  endtask

  initial begin
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) w[i][j] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ws_stream_ctrl.md
Name: systolic_ws_stream_ctrl

Overview:
- Streaming front/back end for the weight-stationary PE array (ROW_NUM x COL_NUM, DATA_WIDTH). Weights are loaded separately.
- Input side: accepts one activation vector per valid/ready handshake and drives skewed wests (row i delayed i cycles), with norths tied to zero.
- Output side: de-skews the array's souths (column j delayed COL_NUM-1-j cycles), buffers completed result vectors in a FIFO, and presents them on a valid/ready output.
- Credit-based admission guarantees results are never dropped, because the array itself cannot stall.

Parameters:
- DATA_WIDTH, 8, element width; all arithmetic is done in the array, modulo 2^DATA_WIDTH.
- ROW_NUM, 8, array rows = activation vector length.
- COL_NUM, 8, array columns = result vector length.
- FIFO_DEPTH, 4, result FIFO entries; must be >= 1. Full throughput needs FIFO_DEPTH >= ROW_NUM+COL_NUM+1.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation vector offered.
- in_ready  out  1  vector accepted when in_valid && in_ready at posedge.
- in_data  in  [DATA_WIDTH-1:0] x [0:ROW_NUM-1]  activation vector.
- wests  out  [DATA_WIDTH-1:0] x [0:ROW_NUM-1]  to array west inputs.
- norths  out  [DATA_WIDTH-1:0] x [0:COL_NUM-1]  to array north inputs; constant 0.
- souths  in  [DATA_WIDTH-1:0] x [0:COL_NUM-1]  from array south outputs.
- out_valid  out  1  result vector at FIFO head.
- out_ready  in  1  pop when out_valid && out_ready at posedge.
- out_data  out  [DATA_WIDTH-1:0] x [0:COL_NUM-1]  result vector.
- busy  out  1  high when any vector is in flight or the FIFO is non-empty.

Behaviour:
- Reset (reset=0, async): all skew/de-skew registers, wests, the valid tracker, FIFO pointers and count, and the in-flight count clear to 0. While in reset: in_ready=0, out_valid=0, busy=0, out_data=0.
- Array PE registers are not reset. Garbage left in the array after reset is never emitted, because the valid tracker is cleared.
- Input skew: on accept at edge E, row i's element is driven on wests[i] during cycle E+1+i (i registers after capture; row 0 registered once). With no accept, zeros enter the skew line (bubble), so idle rows carry 0.
- Back-to-back accepts every cycle are supported; each row's skew line is a pure shift register.
- Valid tracker: shift register of length ROW_NUM+COL_NUM, with a 1 inserted at each accept.
- Array timing: south[j] carries the result for the vector accepted at E during cycle E+1+ROW_NUM+j.
- De-skew: column j is delayed COL_NUM-1-j cycles, so all columns align in cycle E+ROW_NUM+COL_NUM. The aligned vector is written to the FIFO at the end of that cycle if the tracker bit is set. out_valid rises in cycle E+ROW_NUM+COL_NUM+1 when the FIFO was empty.
  - Accept-to-out_valid latency = ROW_NUM+COL_NUM+1 cycles.
- Credits: inflight counts accepted vectors not yet written to the FIFO.
  - in_ready = (inflight + fifo_count) < FIFO_DEPTH, registered-free combinational from counters.
  - Accept and FIFO write on the same edge: inflight unchanged.
  - FIFO pop frees a credit visible the next cycle; a pop and an accept on the same edge are both legal.
- FIFO: circular, pointers wrap at FIFO_DEPTH. Write never happens when full; the credit rule guarantees this.
  - Write while full is a design error: assertion in simulation.
  - Pop when empty is ignored.
  - out_data = head entry, stable while out_valid && !out_ready.
- Results are emitted in acceptance order, exactly once each.
- Reset mid-operation: in-flight and buffered vectors are discarded; the first accept after release behaves as from idle.
- busy = (inflight != 0) || (fifo_count != 0).

Test Plan:
- Single vector, ROW_NUM=COL_NUM=2, weights [[1,2],[3,4]], in_data=[5,6] -> out_valid exactly 5 cycles after accept, out_data=[23,34]. wests[1]=6 exactly one cycle after wests[0]=5.
- 8x8 identity weights, 20 back-to-back vectors, FIFO_DEPTH=17, out_ready=1 -> in_ready never drops, outputs equal inputs in order at one per cycle.
- FIFO_DEPTH=4, out_ready=0, in_valid held high -> exactly 4 accepts then in_ready=0. Raising out_ready for 1 cycle -> one pop and one new accept next cycle.
- Overflow arithmetic, DATA_WIDTH=8, weights all 255, in_data all 255 -> each column = (ROW_NUM*65025) mod 256 = 8 for ROW_NUM=8.
- Assert reset mid-stream with 3 vectors in flight and 2 buffered -> out_valid, busy, in_ready drop immediately. After release no stale result appears; the next vector returns the correct result at nominal latency.
- Out backpressure toggled randomly with weights = random, 100 vectors -> scoreboard match, no loss or duplication, out_data stable while stalled.
